// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, then shifts one
// byte out on device-generated clock edges and checks the device ACK.
module ps2_transmitter #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int SETUP_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int MAX_AB  = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int CNT_MAX = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_BITS,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic          nak_q, nak_d;
    logic          c_oe_q, c_oe_d;
    logic          d_oe_q, d_oe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [7:0]    filt_sh_q;
    logic          filt_q, filt_d;
    logic          filt_prev_q;
    logic          d_meta_q, d_sync_q;
    logic          fall;
    logic          timeout;

    // Clock filter identical to the receiver so both blocks agree on edges.
    always_comb begin
        filt_d = filt_q;
        if (&filt_sh_q) begin
            filt_d = 1'b1;
        end else if (~|filt_sh_q) begin
            filt_d = 1'b0;
        end
    end

    assign fall    = filt_prev_q & ~filt_q;
    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            filt_sh_q   <= 8'h00;
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            d_meta_q    <= 1'b1;
            d_sync_q    <= 1'b1;
        end else begin
            filt_sh_q   <= {ps2c_in, filt_sh_q[7:1]};
            filt_q      <= filt_d;
            filt_prev_q <= filt_q;
            d_meta_q    <= ps2d_in;
            d_sync_q    <= d_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        nak_d     = nak_q;
        c_oe_d    = c_oe_q;
        d_oe_d    = d_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (start) begin
                    // Frame after the start bit: D0..D7, odd parity, stop.
                    frame_d   = {1'b1, ~^data, data};
                    bit_cnt_d = 4'd0;
                    cnt_d     = '0;
                    nak_d     = 1'b0;
                    c_oe_d    = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    d_oe_d  = 1'b1;
                    state_d = S_RTS;
                end
            end
            S_RTS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    c_oe_d  = 1'b0;
                    state_d = S_BITS;
                end
            end
            S_BITS: begin
                if (fall) begin
                    cnt_d     = '0;
                    d_oe_d    = ~frame_q[0];
                    frame_d   = frame_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_d   = '0;
                    nak_d   = d_sync_q;
                    state_d = S_WAIT_IDLE;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    c_oe_d  = 1'b0;
                    d_oe_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                c_oe_d = 1'b0;
                d_oe_d = 1'b0;
                if (filt_q && d_sync_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = nak_q;
                end else if (fall) begin
                    cnt_d = '0;
                end else if (timeout) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                c_oe_d  = 1'b0;
                d_oe_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Line enables are flops with async clear so clr releases the pins at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= 4'd0;
            frame_q   <= 10'h000;
            nak_q     <= 1'b0;
            c_oe_q    <= 1'b0;
            d_oe_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            nak_q     <= nak_d;
            c_oe_q    <= c_oe_d;
            d_oe_q    <= d_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ps2c_oe = c_oe_q;
    assign ps2d_oe = d_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: doc/ps2_transmitter.md
# ps2_transmitter

Host-to-device PS/2 transmitter: sends one 8-bit command byte (for example LED set 0xED or enable 0xF4) from the FPGA to a PS/2 keyboard or mouse. It uses the standard inhibit / request-to-send / device-clocked sequence. The block sits beside the PS/2 receiver on the same ps2c/ps2d pins. It drives the pins only through active-low open-collector enables, so the pad logic pulls a line low when its enable is 1 and releases it otherwise. It filters the clock with the same 8-sample all-equal rule as the receiver, so both blocks see identical clock edges.

## Interface
- INHIBIT_CYCLES, default 2500: clk cycles the clock line is held low before the start bit; 100 µs at 25 MHz.
- SETUP_CYCLES, default 16: clk cycles data and clock are both held low before the clock is released.
- TIMEOUT_CYCLES, default 375000: maximum clk cycles between consecutive detected falling edges in BITS or ACK; 15 ms at 25 MHz.
- clk  in  1  system clock.
- clr  in  1  reset; asynchronous, active-high.
- ps2c_in  in  1  raw PS/2 clock pin value; asynchronous.
- ps2d_in  in  1  raw PS/2 data pin value; asynchronous.
- data  in  8  byte to send; captured on an accepted start.
- start  in  1  one-cycle request; accepted only in IDLE.
- ps2c_oe  out  1  1 = pull the clock line low.
- ps2d_oe  out  1  1 = pull the data line low.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse at the end of every accepted transaction.
- err  out  1  one-cycle pulse coincident with done; 1 = NAK or timeout.

## Operation
- Clock filter: an 8-bit shift register samples ps2c_in every clk.
  - Filtered clock goes to 1 when all 8 samples are 1, to 0 when all 8 are 0, and otherwise holds.
  - Registered previous value gives `fall` = prev & ~filtered.
  - ps2d_in passes through a 2-flop synchronizer only.
- Frame: start bit 0, D0..D7 LSB first, odd parity (total ones in D0..D7 plus parity is odd), stop bit 1.
- Line drive rule: ps2d_oe = ~bit_value, so a 0 bit drives the line low and a 1 bit releases it.
- IDLE: both oe = 0.
  - On start: latch data, compute parity, clear the bit counter, go to INHIBIT.
- INHIBIT: ps2c_oe = 1 for INHIBIT_CYCLES cycles, then go to RTS.
- RTS: ps2c_oe = 1 and ps2d_oe = 1 for SETUP_CYCLES cycles.
  - Then ps2c_oe = 0, zero the timeout counter, go to BITS.
- BITS: ps2d_oe keeps the start bit until the first `fall`.
  - On fall k (k = 1..10), drive bit k: fall 1..8 → D0..D7, fall 9 → parity, fall 10 → stop (ps2d_oe = 0).
  - After fall 10, go to ACK.
- ACK: on the next `fall`, sample synchronized ps2d.
  - 0 = ACK: clean completion.
  - 1 = NAK: set the error flag.
  - Then go to WAIT_IDLE.
- WAIT_IDLE: both oe = 0.
  - When filtered clock = 1 and synchronized ps2d = 1, pulse done (err = error flag) and go to IDLE.
  - Pulse done at the latest after TIMEOUT_CYCLES, with err = 1.
- Timeout: the counter runs in BITS, ACK and WAIT_IDLE and clears on every `fall`.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse done with err = 1, go to IDLE.
- start while busy is ignored; data is not re-latched.
- The receiver is not gated by this block. The system ignores receiver output while busy = 1.

## Timing
- Reset values: state IDLE, ps2c_oe = 0, ps2d_oe = 0, busy = 0, done = 0, err = 0, filter = 0, filtered clock = 1, bit counter = 0.
- clr asserted mid-transaction releases both lines immediately (asynchronous) and emits no done pulse.
- start sampled high in IDLE at edge t:
  - ps2c_oe = 1 and busy = 1 from t+1.
  - ps2d_oe rises at t+1+INHIBIT_CYCLES.
  - ps2c_oe falls at t+1+INHIBIT_CYCLES+SETUP_CYCLES.
- Bit update: ps2d_oe changes on the clk edge after the cycle in which `fall` is 1.
  - Total delay from the pin falling edge is about 10 clk, well within the device's clock-low half-period of 30–50 µs.
- done and err are registered outputs, each high for exactly 1 cycle. busy falls in the same cycle done is high.
- The earliest new start is accepted the cycle after done.

## Test plan
- Send 0xED; the device model clocks at 12.5 kHz and ACKs.
  - Required: ps2d_oe sequence after RTS is start 1, then data 0,1,0,0,1,0,0,0, parity 0 (parity bit = 1), stop 0.
  - Then done = 1, err = 0.
- Send 0xF4 with ACK.
  - Required: data ps2d_oe 1,1,0,1,0,0,0,0, then parity ps2d_oe = 1 (parity bit = 0).
  - Then done with err = 0.
- NAK: the device leaves data high at the 11th falling edge → done with err = 1, both oe = 0.
- No device clock after RTS: after TIMEOUT_CYCLES (set to 1000 in the bench), ps2c_oe = ps2d_oe = 0 and done = err = 1; the next start is accepted.
- start pulsed again during BITS with data 0x00 → ignored; the transmitted byte stays the originally latched value.
- clr asserted during INHIBIT and again during BITS → both oe drop in the same timestep with no done pulse; a following 0xED transfer completes correctly.
